barrel_shifter_pipe: RTL and testbench

Parametrised, pipelined barrel shifter with valid/ready handshakes on both sides. It supports logical and arithmetic shifts and rotates in both directions, and is the datapath shifter for the integer execute unit. The single-cycle fixed 32-bit shifter is superseded by this block when DATA_W or STAGES is not 32/1.

---
 rtl/barrel_shifter_pkg.sv | 37 +++
 rtl/barrel_shifter_pipe_if.sv | 27 ++
 rtl/barrel_shift_level.sv | 30 +++
 rtl/barrel_shifter_pipe.sv | 153 +++++++++++++++
 tb/tb_barrel_shifter_pipe.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/barrel_shifter_pkg.sv
// Shared types and elaboration helpers for the pipelined barrel shifter.
package barrel_shifter_pkg;

    typedef enum logic [2:0] {
        SLL  = 3'b000,
        SRL  = 3'b001,
        SRA  = 3'b010,
        ROL  = 3'b011,
        ROR  = 3'b100,
        PASS = 3'b101
    } shift_op_e;

    // Width of the shift-amount field for a given operand width.
    function automatic int unsigned shamt_w(input int unsigned data_w);
        return $clog2(data_w);
    endfunction

    // Mux levels owned by stage s: floor(l/stages), the first (l mod stages) get one more.
    function automatic int unsigned levels_in_stage(input int unsigned l,
                                                    input int unsigned stages,
                                                    input int unsigned s);
        return (l / stages) + ((s < (l % stages)) ? 1 : 0);
    endfunction

    // Index of the first mux level owned by stage s.
    function automatic int unsigned level_base(input int unsigned l,
                                               input int unsigned stages,
                                               input int unsigned s);
        int unsigned base;
        base = 0;
        for (int unsigned i = 0; i < s; i++) begin
            base += levels_in_stage(l, stages, i);
        end
        return base;
    endfunction

endpackage

// File: rtl/barrel_shifter_pipe_if.sv
// Operand/result handshake bundle for barrel_shifter_pipe.
interface barrel_shifter_pipe_if #(
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned SHAMT_W = barrel_shifter_pkg::shamt_w(DATA_W);

    logic               i_valid;
    logic               o_ready;
    logic [2:0]         i_op;
    logic [SHAMT_W-1:0] i_shift_amt;
    logic [DATA_W-1:0]  i_data;
    logic               o_valid;
    logic               i_ready;
    logic [DATA_W-1:0]  o_data;
    logic               o_zero;

    modport master (
        output i_valid, i_op, i_shift_amt, i_data, i_ready,
        input  o_ready, o_valid, o_data, o_zero
    );

    modport slave (
        input  i_valid, i_op, i_shift_amt, i_data, i_ready,
        output o_ready, o_valid, o_data, o_zero
    );

endinterface

// File: rtl/barrel_shift_level.sv
// One mux level of the barrel shifter: shifts/rotates by SHIFT when en is set.
module barrel_shift_level
    import barrel_shifter_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned SHIFT  = 1
) (
    input  logic [DATA_W-1:0] data,
    input  logic [2:0]        op,
    input  logic              sign,
    input  logic              en,
    output logic [DATA_W-1:0] shifted
);

    // Select the shifted form of data for this level's fixed distance.
    always_comb begin
        shifted = data;
        if (en) begin
            case (shift_op_e'(op))
                SLL:     shifted = {data[DATA_W-1-SHIFT:0], {SHIFT{1'b0}}};
                SRL:     shifted = {{SHIFT{1'b0}}, data[DATA_W-1:SHIFT]};
                SRA:     shifted = {{SHIFT{sign}}, data[DATA_W-1:SHIFT]};
                ROL:     shifted = {data[DATA_W-1-SHIFT:0], data[DATA_W-1:DATA_W-SHIFT]};
                ROR:     shifted = {data[SHIFT-1:0], data[DATA_W-1:SHIFT]};
                default: shifted = data;
            endcase
        end
    end

endmodule

// File: rtl/barrel_shifter_pipe.sv
// Pipelined barrel shifter: log2(DATA_W) mux levels split over STAGES register
// slots with a bubble-collapsing valid/ready chain.
module barrel_shifter_pipe
    import barrel_shifter_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned STAGES = 2
) (
    input logic                  i_clk,
    input logic                  i_rst,
    barrel_shifter_pipe_if.slave bus
);

    localparam int unsigned SHAMT_W = shamt_w(DATA_W);
    localparam int unsigned LEVELS  = SHAMT_W;
    localparam int unsigned LAST    = STAGES - 1;

    // Slot registers; src_q carries the untouched operand for the output check.
    logic               valid_q [STAGES];
    logic [DATA_W-1:0]  data_q  [STAGES];
    logic [2:0]         op_q    [STAGES];
    logic [SHAMT_W-1:0] amt_q   [STAGES];
    logic               sign_q  [STAGES];
    logic [DATA_W-1:0]  src_q   [STAGES];
    logic               zero_q;

    // ready_c[s] means slot s may load this cycle; ready_c[STAGES] is downstream.
    logic [STAGES:0]    ready_c;

    // Inputs seen by each stage's mux group (bus for stage 0, previous slot otherwise).
    logic               up_valid [STAGES];
    logic [DATA_W-1:0]  up_data  [STAGES];
    logic [2:0]         up_op    [STAGES];
    logic [SHAMT_W-1:0] up_amt   [STAGES];
    logic               up_sign  [STAGES];
    logic [DATA_W-1:0]  up_src   [STAGES];
    logic [DATA_W-1:0]  stage_out [STAGES];

    for (genvar s = 0; s < int'(STAGES); s++) begin : g_stage
        localparam int unsigned N    = levels_in_stage(LEVELS, STAGES, s);
        localparam int unsigned BASE = level_base(LEVELS, STAGES, s);

        logic [DATA_W-1:0] chain [N+1];

        if (s == 0) begin : g_src_bus
            assign up_valid[s] = bus.i_valid;
            assign up_data[s]  = bus.i_data;
            assign up_op[s]    = bus.i_op;
            assign up_amt[s]   = bus.i_shift_amt;
            assign up_sign[s]  = bus.i_data[DATA_W-1];
            assign up_src[s]   = bus.i_data;
        end else begin : g_src_slot
            assign up_valid[s] = valid_q[s-1];
            assign up_data[s]  = data_q[s-1];
            assign up_op[s]    = op_q[s-1];
            assign up_amt[s]   = amt_q[s-1];
            assign up_sign[s]  = sign_q[s-1];
            assign up_src[s]   = src_q[s-1];
        end

        assign chain[0] = up_data[s];

        for (genvar j = 0; j < int'(N); j++) begin : g_level
            barrel_shift_level #(
                .DATA_W (DATA_W),
                .SHIFT  (2 ** (BASE + j))
            ) u_level (
                .data    (chain[j]),
                .op      (up_op[s]),
                .sign    (up_sign[s]),
                .en      (up_amt[s][BASE+j]),
                .shifted (chain[j+1])
            );
        end

        assign stage_out[s] = chain[N];
    end

    // Ready ripples back from the consumer: a slot loads if empty or draining.
    always_comb begin
        ready_c         = '0;
        ready_c[STAGES] = bus.i_ready;
        for (int s = int'(STAGES) - 1; s >= 0; s--) begin
            ready_c[s] = !valid_q[s] || ready_c[s+1];
        end
    end

    assign bus.o_ready = ready_c[0] && !i_rst;
    assign bus.o_valid = valid_q[LAST];
    assign bus.o_data  = data_q[LAST];
    assign bus.o_zero  = zero_q;

    // Slot advance; a slot that cannot load keeps its whole payload.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int s = 0; s < int'(STAGES); s++) begin
                valid_q[s] <= 1'b0;
                data_q[s]  <= '0;
                op_q[s]    <= '0;
                amt_q[s]   <= '0;
                sign_q[s]  <= 1'b0;
                src_q[s]   <= '0;
            end
            zero_q <= 1'b1;
        end else begin
            for (int s = 0; s < int'(STAGES); s++) begin
                if (ready_c[s]) begin
                    valid_q[s] <= up_valid[s];
                    if (up_valid[s]) begin
                        data_q[s] <= stage_out[s];
                        op_q[s]   <= up_op[s];
                        amt_q[s]  <= up_amt[s];
                        sign_q[s] <= up_sign[s];
                        src_q[s]  <= up_src[s];
                    end
                end
            end
            if (ready_c[LAST] && up_valid[LAST]) begin
                zero_q <= (stage_out[LAST] == '0);
            end
        end
    end

    // Behavioural form of each op, used only by the output check below.
    function automatic logic [DATA_W-1:0] ref_shift(input logic [DATA_W-1:0]  d,
                                                    input logic [2:0]         op,
                                                    input logic [SHAMT_W-1:0] amt);
        logic [2*DATA_W-1:0] wide;
        wide = {d, d};
        case (shift_op_e'(op))
            SLL:     return d << amt;
            SRL:     return d >> amt;
            SRA:     return DATA_W'($signed(d) >>> amt);
            ROL: begin
                wide = wide << amt;
                return wide[2*DATA_W-1:DATA_W];
            end
            ROR: begin
                wide = wide >> amt;
                return wide[DATA_W-1:0];
            end
            default: return d;
        endcase
    endfunction

    a_ref_model: assert property (@(posedge i_clk) disable iff (i_rst)
        (bus.o_valid && bus.i_ready) |->
            (bus.o_data == ref_shift(src_q[LAST], op_q[LAST], amt_q[LAST])));

    a_hold: assert property (@(posedge i_clk) disable iff (i_rst)
        (bus.o_valid && !bus.i_ready) |=> ($stable(bus.o_data) && bus.o_valid));

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Directed bench for barrel_shifter_pipe (32/2) plus random-op runs on 64/1 and 64/6.
module tb_barrel_shifter_pipe;
    import barrel_shifter_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   vectors = 0;
    int   errors  = 0;

    always #5 clk = ~clk;

    barrel_shifter_pipe_if #(.DATA_W(32)) bus32 ();
    barrel_shifter_pipe_if #(.DATA_W(64)) bus64a ();
    barrel_shifter_pipe_if #(.DATA_W(64)) bus64b ();

    barrel_shifter_pipe #(.DATA_W(32), .STAGES(2)) dut32 (
        .i_clk (clk), .i_rst (rst), .bus (bus32.slave));
    barrel_shifter_pipe #(.DATA_W(64), .STAGES(1)) dut64a (
        .i_clk (clk), .i_rst (rst), .bus (bus64a.slave));
    barrel_shifter_pipe #(.DATA_W(64), .STAGES(6)) dut64b (
        .i_clk (clk), .i_rst (rst), .bus (bus64b.slave));

    // 64-bit stimulus shared by both wide DUTs; sel picks the active one.
    logic        sel;
    logic        v64, rdy64;
    logic [2:0]  op64;
    logic [5:0]  amt64;
    logic [63:0] d64;
    logic        obs_valid, obs_ready, obs_zero;
    logic [63:0] obs_data;

    assign bus64a.i_valid     = v64 && !sel;
    assign bus64b.i_valid     = v64 && sel;
    assign bus64a.i_ready     = sel ? 1'b1 : rdy64;
    assign bus64b.i_ready     = sel ? rdy64 : 1'b1;
    assign bus64a.i_op        = op64;
    assign bus64b.i_op        = op64;
    assign bus64a.i_shift_amt = amt64;
    assign bus64b.i_shift_amt = amt64;
    assign bus64a.i_data      = d64;
    assign bus64b.i_data      = d64;
    assign obs_valid = sel ? bus64b.o_valid : bus64a.o_valid;
    assign obs_ready = sel ? bus64b.o_ready : bus64a.o_ready;
    assign obs_data  = sel ? bus64b.o_data  : bus64a.o_data;
    assign obs_zero  = sel ? bus64b.o_zero  : bus64a.o_zero;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Bit-by-bit definition of each op for the 64-bit runs.
    function automatic logic [63:0] model64(input logic [2:0] op, input int amt,
                                            input logic [63:0] d);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 64; i++) begin
            case (op)
                3'd0:    r[i] = (i >= amt) ? d[i-amt] : 1'b0;
                3'd1:    r[i] = (i + amt < 64) ? d[i+amt] : 1'b0;
                3'd2:    r[i] = (i + amt < 64) ? d[i+amt] : d[63];
                3'd3:    r[i] = d[(i - amt + 64) % 64];
                3'd4:    r[i] = d[(i + amt) % 64];
                default: r[i] = d[i];
            endcase
        end
        return r;
    endfunction

    // One beat through the 32-bit DUT with i_ready held high; result due two edges later.
    task automatic single32(input logic [2:0] op, input logic [4:0] amt,
                            input logic [31:0] data, input logic [31:0] exp, input string tag);
        bus32.i_valid     = 1'b1;
        bus32.i_op        = op;
        bus32.i_shift_amt = amt;
        bus32.i_data      = data;
        #1;
        check({tag, " ready"}, 64'(bus32.o_ready), 64'(1));
        step;
        bus32.i_valid = 1'b0;
        #1;
        check({tag, " early valid"}, 64'(bus32.o_valid), 64'(0));
        step;
        #1;
        check({tag, " valid"}, 64'(bus32.o_valid), 64'(1));
        check(tag, 64'(bus32.o_data), 64'(exp));
        check({tag, " zero"}, 64'(bus32.o_zero), 64'(exp == 32'h0));
        step;
    endtask

    // Random valid/ready stream on the selected 64-bit DUT, scored in order.
    task automatic run64(input int nbeats, input string tag);
        logic [63:0] exp_q [$];
        logic [63:0] e;
        int sent;
        int got;
        sent = 0;
        got  = 0;
        for (int cyc = 0; cyc < 1000 && got < nbeats; cyc++) begin
            v64   = (sent < nbeats) && ($urandom_range(0, 3) != 0);
            op64  = 3'($urandom_range(0, 7));
            amt64 = 6'($urandom_range(0, 63));
            d64   = {$urandom, $urandom};
            rdy64 = ($urandom_range(0, 3) != 0);
            #1;
            if (obs_valid && rdy64) begin
                if (exp_q.size() == 0) begin
                    check({tag, " unexpected beat"}, 64'(obs_valid), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    check({tag, " data"}, obs_data, e);
                    check({tag, " zero"}, 64'(obs_zero), 64'(e == 64'h0));
                    got++;
                end
            end
            if (v64 && obs_ready) begin
                exp_q.push_back(model64(op64, int'(amt64), d64));
                sent++;
            end
            step;
        end
        v64   = 1'b0;
        rdy64 = 1'b1;
        check({tag, " count"}, 64'(got), 64'(nbeats));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] bp_exp [8];
        int sent;
        int got;

        bp_exp = '{32'h0000_0003, 32'h0000_0030, 32'h0000_0300, 32'h0000_3000,
                   32'h0003_0000, 32'h0030_0000, 32'h0300_0000, 32'h3000_0000};

        rst = 1'b1;
        sel = 1'b0; v64 = 1'b0; rdy64 = 1'b1; op64 = '0; amt64 = '0; d64 = '0;
        bus32.i_valid     = 1'b1;
        bus32.i_op        = 3'b000;
        bus32.i_shift_amt = 5'd4;
        bus32.i_data      = 32'hDEAD_BEEF;
        bus32.i_ready     = 1'b1;

        // Reset held for three cycles with a valid beat offered
        for (int c = 0; c < 3; c++) begin
            step;
            #1;
            check("rst o_valid", 64'(bus32.o_valid), 64'(0));
            check("rst o_data",  64'(bus32.o_data),  64'(0));
            check("rst o_zero",  64'(bus32.o_zero),  64'(1));
            check("rst o_ready", 64'(bus32.o_ready), 64'(0));
        end
        rst = 1'b0;
        bus32.i_valid = 1'b0;
        #1;
        check("post-rst o_ready", 64'(bus32.o_ready), 64'(1));

        // Every op on the same operand
        single32(3'b000, 5'd4, 32'h8000_00F1, 32'h0000_0F10, "SLL");
        single32(3'b001, 5'd4, 32'h8000_00F1, 32'h0800_000F, "SRL");
        single32(3'b010, 5'd4, 32'h8000_00F1, 32'hF800_000F, "SRA");
        single32(3'b011, 5'd4, 32'h8000_00F1, 32'h0000_0F18, "ROL");
        single32(3'b100, 5'd4, 32'h8000_00F1, 32'h1800_000F, "ROR");
        single32(3'b110, 5'd4, 32'h8000_00F1, 32'h8000_00F1, "PASS6");

        // Boundary amounts
        single32(3'b010, 5'd31, 32'h8000_0000, 32'hFFFF_FFFF, "SRA31");
        single32(3'b000, 5'd31, 32'h0000_0001, 32'h8000_0000, "SLL31");
        single32(3'b011, 5'd31, 32'h8000_0001, 32'hC000_0000, "ROL31");
        single32(3'b100, 5'd31, 32'h8000_0001, 32'h0000_0003, "ROR31");
        single32(3'b010, 5'd0,  32'h8000_00F1, 32'h8000_00F1, "SRA0");
        single32(3'b100, 5'd0,  32'h8000_00F1, 32'h8000_00F1, "ROR0");
        single32(3'b111, 5'd5,  32'h1234_5678, 32'h1234_5678, "PASS7");
        single32(3'b001, 5'd1,  32'h0000_0001, 32'h0000_0000, "SRL to zero");

        // Backpressure: 8 ROL beats, i_ready low in cycles 3..7
        sent = 0;
        got  = 0;
        bus32.i_op   = 3'b011;
        bus32.i_data = 32'h0000_0003;
        for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
            bus32.i_valid     = (sent < 8);
            bus32.i_shift_amt = 5'(sent * 4);
            bus32.i_ready     = !(cyc >= 3 && cyc <= 7);
            #1;
            check("bp o_ready", 64'(bus32.o_ready), 64'(cyc < 3 || cyc > 7));
            if (bus32.o_valid) begin
                check("bp o_data", 64'(bus32.o_data), 64'(bp_exp[got & 7]));
                if (bus32.i_ready) got++;
            end
            if (bus32.i_valid && bus32.o_ready) sent++;
            step;
        end
        bus32.i_valid = 1'b0;
        bus32.i_ready = 1'b1;
        check("bp beat count", 64'(got), 64'(8));
        step;

        // Bubble collapse with the consumer stalled
        bus32.i_ready     = 1'b0;
        bus32.i_valid     = 1'b1;
        bus32.i_op        = 3'b010;
        bus32.i_shift_amt = 5'd8;
        bus32.i_data      = 32'hF000_0000;
        #1;
        check("bub c0 o_ready", 64'(bus32.o_ready), 64'(1));
        step;
        bus32.i_valid = 1'b0;
        #1;
        check("bub c1 o_valid", 64'(bus32.o_valid), 64'(0));
        step;
        bus32.i_valid     = 1'b1;
        bus32.i_op        = 3'b100;
        bus32.i_shift_amt = 5'd8;
        bus32.i_data      = 32'h0000_00AB;
        #1;
        check("bub c2 o_valid", 64'(bus32.o_valid), 64'(1));
        check("bub c2 o_ready", 64'(bus32.o_ready), 64'(1));
        step;
        bus32.i_valid = 1'b0;
        #1;
        check("bub full o_ready", 64'(bus32.o_ready), 64'(0));
        bus32.i_ready = 1'b1;
        #1;
        check("bub comb o_ready", 64'(bus32.o_ready), 64'(1));
        check("bub first o_data", 64'(bus32.o_data), 64'(32'hFFF0_0000));
        step;
        #1;
        check("bub second o_valid", 64'(bus32.o_valid), 64'(1));
        check("bub second o_data", 64'(bus32.o_data), 64'(32'hAB00_0000));
        step;
        #1;
        check("bub drained", 64'(bus32.o_valid), 64'(0));

        // Reset with two beats in flight
        bus32.i_ready     = 1'b0;
        bus32.i_valid     = 1'b1;
        bus32.i_op        = 3'b000;
        bus32.i_shift_amt = 5'd1;
        bus32.i_data      = 32'h0000_0001;
        step;
        bus32.i_data = 32'h0000_0002;
        step;
        bus32.i_valid = 1'b0;
        #1;
        check("mid pre-rst o_valid", 64'(bus32.o_valid), 64'(1));
        rst = 1'b1;
        step;
        #1;
        check("mid rst o_valid", 64'(bus32.o_valid), 64'(0));
        check("mid rst o_data",  64'(bus32.o_data),  64'(0));
        check("mid rst o_zero",  64'(bus32.o_zero),  64'(1));
        rst = 1'b0;
        bus32.i_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            check("mid no ghost beat", 64'(bus32.o_valid), 64'(0));
            step;
        end

        // Random ops on the 64-bit variants, with a mid-stream reset each
        for (int k = 0; k < 2; k++) begin
            sel = k[0];
            run64(24, k == 0 ? "w64s1" : "w64s6");
            v64   = 1'b1;
            rdy64 = 1'b0;
            op64  = 3'b011;
            amt64 = 6'd9;
            d64   = 64'h0123_4567_89AB_CDEF;
            step;
            step;
            v64 = 1'b0;
            rst = 1'b1;
            step;
            #1;
            check(k == 0 ? "w64s1 rst o_valid" : "w64s6 rst o_valid", 64'(obs_valid), 64'(0));
            rst   = 1'b0;
            rdy64 = 1'b1;
            step;
            run64(12, k == 0 ? "w64s1 post-rst" : "w64s6 post-rst");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
